// File: rtl/priority_encoder_16to4_pkg.sv
// ============================================================================
// priority_encoder_16to4_pkg : shared widths and constants for the encoder
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package priority_encoder_16to4_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_SEL_W = $clog2(DEF_WIDTH);

   localparam logic [DEF_WIDTH-1:0] NO_REQ = '0;

endpackage

`default_nettype wire

// File: rtl/priority_encoder_16to4_if.sv
// ============================================================================
// priority_encoder_16to4_if : request bus and index handshake of the encoder
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface priority_encoder_16to4_if
   import priority_encoder_16to4_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEL_W = $clog2(WIDTH)
);

   logic             enable;
   logic [WIDTH-1:0] D;
   logic [SEL_W-1:0] sel;
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] pending;
   logic             overrun;

   modport master (
      output enable, D, ready,
      input  sel, valid, pending, overrun
   );

   modport slave (
      input  enable, D, ready,
      output sel, valid, pending, overrun
   );

endinterface

`default_nettype wire

// File: rtl/priority_find_msb.sv
// ============================================================================
// priority_find_msb : combinational index of the highest set bit of a vector
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module priority_find_msb
   import priority_encoder_16to4_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEL_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [SEL_W-1:0] idx_o,
   output logic             found_o
);

   // Ascending scan: the last hit, i.e. the highest set bit, wins.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (vec_i[i]) begin
            idx_o   = SEL_W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/priority_encoder_16to4.sv
// ============================================================================
// priority_encoder_16to4 : pending-request register drained highest index first
// over a valid/ready handshake. Optional sticky overrun flag is enabled by
// defining PRIORITY_ENCODER_OVERRUN_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module priority_encoder_16to4
   import priority_encoder_16to4_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEL_W = $clog2(WIDTH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   priority_encoder_16to4_if.slave    bus
);

   localparam logic [WIDTH-1:0] ZERO_VEC = WIDTH'(NO_REQ);
   localparam logic [WIDTH-1:0] ONE_VEC  = WIDTH'(1);

   logic [WIDTH-1:0] pending_q, pending_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             valid_q, valid_d;

   logic             transfer;
   logic             slot_free;
   logic [WIDTH-1:0] held_mask;
   logic [WIDTH-1:0] clr_mask;
   logic [WIDTH-1:0] eligible;
   logic [WIDTH-1:0] new_req;
   logic [SEL_W-1:0] msb_idx;
   logic             msb_found;

   assign transfer  = valid_q & bus.ready;
   assign slot_free = ~valid_q | transfer;

   // The index on sel stays pending until accepted; it is masked from
   // re-selection while held and cleared on the accepting edge.
   assign held_mask = valid_q  ? (ONE_VEC << sel_q) : ZERO_VEC;
   assign clr_mask  = transfer ? held_mask          : ZERO_VEC;
   assign eligible  = pending_q & ~held_mask;
   assign new_req   = bus.enable ? bus.D : ZERO_VEC;

   priority_find_msb #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_find_msb (
      .vec_i   (eligible),
      .idx_o   (msb_idx),
      .found_o (msb_found)
   );

   always_comb begin
      pending_d = (pending_q & ~clr_mask) | new_req;
      sel_d     = sel_q;
      valid_d   = valid_q;
      if (slot_free) begin
         valid_d = msb_found;
         if (msb_found) begin
            sel_d = msb_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         sel_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         sel_q     <= sel_d;
         valid_q   <= valid_d;
      end
   end

`ifdef PRIORITY_ENCODER_OVERRUN_EN
   logic overrun_q, overrun_d;

   // A request arriving for an index still pending (and not retired this
   // edge) is lost by merging; flag it until reset.
   assign overrun_d = overrun_q | (|(new_req & pending_q & ~clr_mask));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

   assign bus.overrun = overrun_q;
`else
   assign bus.overrun = 1'b0;
`endif

   assign bus.sel     = sel_q;
   assign bus.valid   = valid_q;
   assign bus.pending = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder_16to4.sv
// ============================================================================
// tb_priority_encoder_16to4 : directed and randomized checks of the encoder
// against a bit-array reference model. Honors PRIORITY_ENCODER_OVERRUN_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_priority_encoder_16to4;
   import priority_encoder_16to4_pkg::*;

`ifdef PRIORITY_ENCODER_OVERRUN_EN
   localparam bit OVR_ON = 1'b1;
`else
   localparam bit OVR_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   priority_encoder_16to4_if #(.WIDTH(DEF_WIDTH), .SEL_W(DEF_SEL_W)) bus ();

   priority_encoder_16to4 #(.WIDTH(DEF_WIDTH), .SEL_W(DEF_SEL_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int passed = 0;
   int total  = 0;

   // Reference model: a set of outstanding request indices plus the offered one.
   bit m_pend [16];
   int m_sel;
   bit m_valid;
   bit m_ovr;

   function automatic logic [15:0] m_pend_vec();
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
      m_sel   = 0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   // Advance the model by one edge using the inputs currently driven, then
   // let the DUT take the same edge and settle.
   task automatic step();
      int  acc;
      int  g;
      bit  free;
      acc  = (m_valid && bus.ready) ? m_sel : -1;
      free = !m_valid || (acc >= 0);
      g    = -1;
      if (free) begin
         for (int i = 15; i >= 0; i--) begin
            if (m_pend[i] && i != acc) begin
               g = i;
               break;
            end
         end
      end
      if (OVR_ON && bus.enable) begin
         for (int i = 0; i < 16; i++)
            if (bus.D[i] && m_pend[i] && i != acc) m_ovr = 1'b1;
      end
      if (free) begin
         if (g >= 0) begin
            m_sel   = g;
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
      end
      if (acc >= 0) m_pend[acc] = 1'b0;
      if (bus.enable)
         for (int i = 0; i < 16; i++) if (bus.D[i]) m_pend[i] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      bus.enable = 1'b0;
      bus.D      = '0;
      bus.ready  = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      bus.enable = 1'b1;
      bus.D      = 16'hFFFF;
      bus.ready  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({bus.pending, bus.valid, bus.sel, bus.overrun} !== {16'h0, 1'b0, 4'h0, 1'b0})
         $display("FAIL reset_state: got pend=%h valid=%b sel=%0d ovr=%b, want all zero",
                  bus.pending, bus.valid, bus.sel, bus.overrun);
      else passed++;

      rst_n = 1'b1;
      step();
      bus.enable = 1'b0;
      total++;
      if (bus.valid !== 1'b0 || bus.pending !== 16'hFFFF)
         $display("FAIL reset_first_edge: got valid=%b pend=%h, want valid=0 pend=ffff",
                  bus.valid, bus.pending);
      else passed++;

      step();
      total++;
      if (bus.valid !== 1'b1 || bus.sel !== 4'd15)
         $display("FAIL reset_second_edge: got valid=%b sel=%0d, want valid=1 sel=15",
                  bus.valid, bus.sel);
      else passed++;

      // Asynchronous reset while an index is being offered.
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if ({bus.pending, bus.valid, bus.sel, bus.overrun} !== {16'h0, 1'b0, 4'h0, 1'b0})
         $display("FAIL reset_async_mid: got pend=%h valid=%b sel=%0d ovr=%b, want all zero",
                  bus.pending, bus.valid, bus.sel, bus.overrun);
      else passed++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      bus.enable = 1'b1;
      bus.D      = 16'h0020;
      bus.ready  = 1'b1;
      step();
      bus.enable = 1'b0;
      bus.D      = '0;
      step();
      total++;
      if (bus.valid !== 1'b1 || bus.sel !== 4'd5)
         $display("FAIL single_grant: got valid=%b sel=%0d, want valid=1 sel=5", bus.valid, bus.sel);
      else passed++;
      step();
      total++;
      if (bus.valid !== 1'b0 || bus.pending !== 16'h0)
         $display("FAIL single_drain: got valid=%b pend=%h, want valid=0 pend=0000",
                  bus.valid, bus.pending);
      else passed++;
   endtask

   task automatic test_backpressure();
      logic [3:0] seq [3];
      seq[0] = 4'd15; seq[1] = 4'd8; seq[2] = 4'd0;
      bus.ready  = 1'b0;
      bus.enable = 1'b1;
      bus.D      = 16'h8101;
      step();
      bus.enable = 1'b0;
      bus.D      = '0;
      for (int c = 0; c < 4; c++) begin
         step();
         total++;
         if (bus.valid !== 1'b1 || bus.sel !== 4'd15)
            $display("FAIL backpressure_hold[%0d]: got valid=%b sel=%0d, want valid=1 sel=15",
                     c, bus.valid, bus.sel);
         else passed++;
      end
      bus.ready = 1'b1;
      for (int k = 1; k < 3; k++) begin
         step();
         total++;
         if (bus.valid !== 1'b1 || bus.sel !== seq[k])
            $display("FAIL backpressure_seq[%0d]: got valid=%b sel=%0d, want valid=1 sel=%0d",
                     k, bus.valid, bus.sel, seq[k]);
         else passed++;
      end
      step();
      total++;
      if (bus.valid !== 1'b0 || bus.pending !== 16'h0)
         $display("FAIL backpressure_end: got valid=%b pend=%h, want valid=0 pend=0000",
                  bus.valid, bus.pending);
      else passed++;
   endtask

   task automatic test_clear_set();
      bus.ready  = 1'b0;
      bus.enable = 1'b1;
      bus.D      = 16'h0008;
      step();
      bus.enable = 1'b0;
      bus.D      = '0;
      step();
      total++;
      if (bus.valid !== 1'b1 || bus.sel !== 4'd3)
         $display("FAIL clear_set_grant: got valid=%b sel=%0d, want valid=1 sel=3", bus.valid, bus.sel);
      else passed++;
      bus.ready  = 1'b1;
      bus.enable = 1'b1;
      bus.D      = 16'h0008;
      step();
      bus.enable = 1'b0;
      bus.D      = '0;
      total++;
      if (bus.pending !== 16'h0008 || bus.valid !== 1'b0)
         $display("FAIL clear_set_requeue: got pend=%h valid=%b, want pend=0008 valid=0",
                  bus.pending, bus.valid);
      else passed++;
      step();
      total++;
      if (bus.valid !== 1'b1 || bus.sel !== 4'd3)
         $display("FAIL clear_set_regrant: got valid=%b sel=%0d, want valid=1 sel=3", bus.valid, bus.sel);
      else passed++;
      step();
      total++;
      if (bus.valid !== 1'b0 || bus.pending !== 16'h0 || bus.overrun !== 1'b0)
         $display("FAIL clear_set_drain: got valid=%b pend=%h ovr=%b, want 0 0000 0",
                  bus.valid, bus.pending, bus.overrun);
      else passed++;
   endtask

   task automatic test_enable_gating();
      bus.enable = 1'b0;
      bus.D      = 16'hFFFF;
      bus.ready  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         total++;
         if (bus.pending !== 16'h0 || bus.valid !== 1'b0)
            $display("FAIL enable_gating[%0d]: got pend=%h valid=%b, want pend=0000 valid=0",
                     c, bus.pending, bus.valid);
         else passed++;
      end
      bus.D = '0;
   endtask

   task automatic test_overrun();
      bus.ready  = 1'b0;
      bus.enable = 1'b1;
      bus.D      = 16'h0004;
      step();
      total++;
      if (bus.overrun !== 1'b0)
         $display("FAIL overrun_first: got %b, want 0", bus.overrun);
      else passed++;
      step();
      total++;
      if (bus.overrun !== OVR_ON)
         $display("FAIL overrun_second: got %b, want %b", bus.overrun, OVR_ON);
      else passed++;
      bus.enable = 1'b0;
      bus.D      = '0;
      bus.ready  = 1'b1;
      repeat (3) step();
      total++;
      if (bus.overrun !== OVR_ON || bus.valid !== 1'b0)
         $display("FAIL overrun_sticky: got ovr=%b valid=%b, want ovr=%b valid=0",
                  bus.overrun, bus.valid, OVR_ON);
      else passed++;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (bus.overrun !== 1'b0)
         $display("FAIL overrun_reset: got %b, want 0", bus.overrun);
      else passed++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         bus.enable = ($urandom_range(0, 3) != 0);
         bus.D      = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
         bus.ready  = ($urandom_range(0, 2) != 0);
         step();
         total++;
         if (bus.valid !== m_valid || bus.pending !== m_pend_vec() ||
             bus.overrun !== m_ovr || (m_valid && bus.sel !== 4'(m_sel))) begin
            errs++;
            if (errs <= 10)
               $display("FAIL random[%0d]: got valid=%b sel=%0d pend=%h ovr=%b, want valid=%b sel=%0d pend=%h ovr=%b",
                        c, bus.valid, bus.sel, bus.pending, bus.overrun,
                        m_valid, m_sel, m_pend_vec(), m_ovr);
         end else passed++;
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.enable = 1'b0;
      bus.D      = '0;
      bus.ready  = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_clear_set();
      test_enable_gating();
      test_overrun();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/priority_encoder_16to4.md
Name: priority_encoder_16to4

Overview:
- Sequential 16-to-4 priority encoder; the inverse end of the 4-to-16 decoder (sel/enable -> one-hot D).
- Collects request bits from a 16-bit D bus into a pending register.
- Emits one 4-bit index at a time, highest set index first, over a valid/ready handshake.
- Clears each bit once its index is accepted; sits between request sources and any consumer that drives a decoder from the index.

Parameters:
- WIDTH, 16, number of request lines in D.
- SEL_W, 4, index width; equals $clog2(WIDTH); must not be overridden independently.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  when 1, D is sampled into pending on the clock edge.
- D  input  WIDTH  request bits; bit i requests index i.
- sel  output  SEL_W  encoded index; registered.
- valid  output  1  sel holds an ungranted index; registered.
- ready  input  1  consumer accepts sel this cycle when valid=1.
- pending  output  WIDTH  registered pending-request vector, for observation.
- overrun  output  1  sticky error flag (see Optional Feature); registered.

Behaviour:
- Reset (rst_n=0, asynchronous): pending=0, sel=0, valid=0, overrun=0. Reset mid-handshake discards the held index and all pending bits. Outputs stay 0 until the first edge after release.
- Transfer: occurs on any edge with valid=1 and ready=1.
- Slot free: valid=0, or a transfer occurs this edge.
- Grant: on an edge with slot free and (pending & ~clr) != 0:
  - sel <= highest set index of pending, valid <= 1.
  - That bit is added to the clear mask.
  - Bits arriving on D in the same cycle are not eligible until the next edge.
- Idle: on an edge with slot free and nothing eligible, valid <= 0 and sel holds its last value.
- Hold: while valid=1 and ready=0, sel and valid are stable.
- Pending update: pending_next = (pending & ~grant_mask) | (enable ? D : 0). A D bit set wins over a same-edge clear of the same bit, so the request re-queues.
- Latency:
  - D sampled at edge N.
  - Index visible (valid=1) after edge N+1 if the slot is free.
  - Back-to-back grants every cycle while ready=1.
- enable=0: D is ignored; draining continues.
- Priority is fixed: index 15 is highest, 0 lowest. Lower bits may starve under continuous high requests; this is accepted.
- D=0 with enable=1 is a no-op.

Optional Feature:
- Macro: PRIORITY_ENCODER_OVERRUN_EN.
- Defined:
  - overrun <= 1 on any edge where enable=1 and (D & pending) != 0, excluding bits granted on that same edge.
  - overrun clears only on reset.
- Undefined: overrun is tied to constant 0; no extra logic.

Decomposition:
- Shared package holds: WIDTH default (16), SEL_W default (4), and a localparam for the all-zero request vector.
- One natural sub-module: priority_find_msb.
  - Combinational; input WIDTH vector; outputs SEL_W index and a found flag.
  - Reusable by other encoders in the codebase.
- Handshake and pending register stay in the top module.

Test Plan:
1. Reset: hold rst_n=0 with D=16'hFFFF, enable=1 -> pending=0, valid=0, sel=0, overrun=0. Release rst_n -> first grant appears after the second edge.
2. Single request: D=16'h0020, enable=1 for one cycle, ready=1 -> valid=1 with sel=4'd5 for exactly one cycle, then valid=0 and pending=0.
3. Multi request with backpressure: D=16'h8101 once, ready=0 for 3 cycles -> sel=4'd15 held stable with valid=1. Then ready=1 -> sel sequence 15, 8, 0 on consecutive cycles, then valid=0.
4. Simultaneous clear/set: pending=16'h0008 granted (sel=3) while ready=1 and D=16'h0008, enable=1 on the accept edge -> bit 3 remains pending, and sel=3 is granted again on the next edge.
5. Enable gating: D=16'hFFFF with enable=0 for 5 cycles -> pending stays 0 and valid stays 0.
6. Overrun: PRIORITY_ENCODER_OVERRUN_EN defined, ready=0, D=16'h0004 on two consecutive edges -> overrun=1 after the second edge and stays 1 until rst_n=0. Macro undefined -> overrun stays 0.
